sd_spi_responder: RTL

SPI-mode microSD card responder: the card end of the SD-over-SPI link. Receives 48-bit command frames on MOSI, returns R1/R7 responses on MISO, and serves CMD17 single-block reads as a data-token stream fetched from a 32-bit word memory. It replaces a physical card in simulation and FPGA loopback, and sits behind the SPI pins opposite the SD host controller.

---
 rtl/sd_spi_responder.sv | 275 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/sd_spi_responder.sv
// sd_spi_responder: SPI-mode microSD card model answering CMD0/8/55/41/17 from a 32-bit word memory
module sd_spi_responder #(
    parameter int ADDR_W    = 16,
    parameter int NCR_BYTES = 1,
    parameter int NAC_BYTES = 2
) (
    input  logic              sdr_clk_i,
    input  logic              sdr_rst_i,
    input  logic              sck_i,
    input  logic              ss_i,
    input  logic              mosi_i,
    output logic              miso_o,
    output logic              miso_oe_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic              mem_re_o,
    input  logic [31:0]       mem_data_i,
    output logic              card_idle_o,
    output logic              cmd_valid_o,
    output logic [5:0]        cmd_index_o,
    output logic [31:0]       cmd_arg_o
);
    localparam logic [2:0] WAIT_CMD = 3'd0;
    localparam logic [2:0] CMD_RX   = 3'd1;
    localparam logic [2:0] NCR      = 3'd2;
    localparam logic [2:0] RESP     = 3'd3;
    localparam logic [2:0] NAC      = 3'd4;
    localparam logic [2:0] TOKEN    = 3'd5;
    localparam logic [2:0] DATA     = 3'd6;
    localparam logic [2:0] CRC      = 3'd7;

    logic [1:0]        sck_sync_q, ss_sync_q, mosi_sync_q;
    logic              sck_prev_q;
    logic              sck_s, ss_s, mosi_s, sck_rise, sck_fall, byte_done;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_sh_q;
    logic [7:0]        tx_sh_q, rx_byte, tx_byte;
    logic [2:0]        state_q, state_d;
    logic [8:0]        cnt_q, cnt_d, nxt;
    logic [5:0]        idx_q, idx_d, cmd_index_q, cmd_index_d;
    logic [31:0]       arg_q, arg_d, cmd_arg_q, cmd_arg_d, word_q;
    logic [39:0]       resp_q, resp_d;
    logic [7:0]        r1;
    logic              r7_q, r7_d, rd_q, rd_d, idle_q, idle_d, app_q, app_d, oor;
    logic              cmd_valid_q, cmd_valid_d, mem_re_q, mem_re_d, rd_pend_q;
    logic [ADDR_W-8:0] base_q, base_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;

    assign sck_s       = sck_sync_q[1];
    assign ss_s        = ss_sync_q[1];
    assign mosi_s      = mosi_sync_q[1];
    assign sck_rise    = sck_s & ~sck_prev_q;
    assign sck_fall    = ~sck_s & sck_prev_q;
    assign byte_done   = sck_rise && bit_cnt_q == 3'd7 && !ss_s;
    assign rx_byte     = {rx_sh_q, mosi_s};
    assign oor         = |(arg_q >> (ADDR_W - 7));
    assign miso_o      = ss_s | tx_sh_q[7];
    assign miso_oe_o   = ~ss_s;
    assign mem_addr_o  = mem_addr_q;
    assign mem_re_o    = mem_re_q;
    assign card_idle_o = idle_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_index_o = cmd_index_q;
    assign cmd_arg_o   = cmd_arg_q;

    // two-flop synchronizers for the asynchronous SPI pins, plus SCK history for edge detection
    always_ff @(posedge sdr_clk_i) begin
        if (sdr_rst_i) begin
            sck_sync_q  <= 2'b00;
            ss_sync_q   <= 2'b11;
            mosi_sync_q <= 2'b11;
            sck_prev_q  <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], sck_i};
            ss_sync_q   <= {ss_sync_q[0], ss_i};
            mosi_sync_q <= {mosi_sync_q[0], mosi_i};
            sck_prev_q  <= sck_s;
        end
    end

    // byte engine: sample MOSI on SCK rise, reload TX at each 8th rise, shift MISO on the falls in between
    always_ff @(posedge sdr_clk_i) begin
        if (sdr_rst_i || ss_s) begin
            bit_cnt_q <= '0;
            rx_sh_q   <= '0;
            tx_sh_q   <= 8'hFF;
        end else if (sck_rise) begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            rx_sh_q   <= {rx_sh_q[5:0], mosi_s};
            if (bit_cnt_q == 3'd7)
                tx_sh_q <= tx_byte;
        end else if (sck_fall && bit_cnt_q != 3'd0) begin
            tx_sh_q <= {tx_sh_q[6:0], 1'b1};
        end
    end

    // card FSM: advances only at byte boundaries and picks the next byte to transmit
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        arg_d       = arg_q;
        resp_d      = resp_q;
        r7_d        = r7_q;
        rd_d        = rd_q;
        idle_d      = idle_q;
        app_d       = app_q;
        base_d      = base_q;
        cmd_index_d = cmd_index_q;
        cmd_arg_d   = cmd_arg_q;
        mem_addr_d  = mem_addr_q;
        cmd_valid_d = 1'b0;
        mem_re_d    = 1'b0;
        tx_byte     = 8'hFF;
        r1          = {5'b0, 1'b1, 1'b0, idle_q};
        nxt         = cnt_q + 9'd1;
        if (ss_s) begin
            state_d = WAIT_CMD;
            cnt_d   = '0;
        end else if (byte_done) begin
            case (state_q)
                WAIT_CMD: begin
                    if (rx_byte[7:6] == 2'b01) begin
                        idx_d   = rx_byte[5:0];
                        state_d = CMD_RX;
                        cnt_d   = '0;
                    end
                end
                CMD_RX: begin
                    if (cnt_q != 9'd4) begin
                        arg_d = {arg_q[23:0], rx_byte};
                        cnt_d = nxt;
                    end else begin
                        cmd_valid_d = 1'b1;
                        cmd_index_d = idx_q;
                        cmd_arg_d   = arg_q;
                        app_d       = 1'b0;
                        r7_d        = 1'b0;
                        rd_d        = 1'b0;
                        base_d      = arg_q[ADDR_W-8:0];
                        case (idx_q)
                            6'd0: begin
                                idle_d = 1'b1;
                                r1     = 8'h01;
                            end
                            6'd8: begin
                                r1   = {7'd0, idle_q};
                                r7_d = 1'b1;
                            end
                            6'd55: begin
                                r1    = {7'd0, idle_q};
                                app_d = 1'b1;
                            end
                            6'd41: begin
                                if (app_q) begin
                                    idle_d = 1'b0;
                                    r1     = 8'h00;
                                end
                            end
                            6'd17: begin
                                r1   = idle_q ? 8'h05 : oor ? 8'h40 : 8'h00;
                                rd_d = !idle_q && !oor;
                            end
                            default: ;
                        endcase
                        resp_d  = {r1, 16'h0000, 4'h0, arg_q[11:0]};
                        state_d = NCR;
                        cnt_d   = 9'd1;
                    end
                end
                NCR: begin
                    if (cnt_q == 9'(NCR_BYTES)) begin
                        tx_byte = resp_q[39:32];
                        resp_d  = resp_q << 8;
                        state_d = RESP;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = nxt;
                    end
                end
                RESP: begin
                    if (r7_q && cnt_q < 9'd4) begin
                        tx_byte = resp_q[39:32];
                        resp_d  = resp_q << 8;
                        cnt_d   = nxt;
                    end else begin
                        state_d = rd_q ? NAC : WAIT_CMD;
                        cnt_d   = rd_q ? 9'd1 : 9'd0;
                    end
                end
                NAC: begin
                    if (cnt_q == 9'(NAC_BYTES)) begin
                        tx_byte    = 8'hFE;
                        state_d    = TOKEN;
                        mem_re_d   = 1'b1;
                        mem_addr_d = {base_q, 7'd0};
                    end else begin
                        cnt_d = nxt;
                    end
                end
                TOKEN: begin
                    tx_byte = word_q[31:24];
                    state_d = DATA;
                    cnt_d   = '0;
                end
                DATA: begin
                    if (cnt_q == 9'd511) begin
                        state_d = CRC;
                        cnt_d   = '0;
                    end else begin
                        tx_byte = word_q[{~nxt[1:0], 3'b000} +: 8];
                        cnt_d   = nxt;
                        if (nxt[1:0] == 2'd3 && nxt[8:2] != 7'h7F) begin
                            mem_re_d   = 1'b1;
                            mem_addr_d = {base_q, nxt[8:2] + 7'd1};
                        end
                    end
                end
                CRC: begin
                    state_d = cnt_q[0] ? WAIT_CMD : CRC;
                    cnt_d   = cnt_q[0] ? 9'd0 : 9'd1;
                end
                default: state_d = WAIT_CMD;
            endcase
        end
    end

    // FSM and card-status registers
    always_ff @(posedge sdr_clk_i) begin
        if (sdr_rst_i) begin
            state_q     <= WAIT_CMD;
            cnt_q       <= '0;
            idx_q       <= '0;
            arg_q       <= '0;
            resp_q      <= '0;
            r7_q        <= 1'b0;
            rd_q        <= 1'b0;
            idle_q      <= 1'b1;
            app_q       <= 1'b0;
            base_q      <= '0;
            cmd_index_q <= '0;
            cmd_arg_q   <= '0;
            cmd_valid_q <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            arg_q       <= arg_d;
            resp_q      <= resp_d;
            r7_q        <= r7_d;
            rd_q        <= rd_d;
            idle_q      <= idle_d;
            app_q       <= app_d;
            base_q      <= base_d;
            cmd_index_q <= cmd_index_d;
            cmd_arg_q   <= cmd_arg_d;
            cmd_valid_q <= cmd_valid_d;
            mem_re_q    <= mem_re_d;
            mem_addr_q  <= mem_addr_d;
        end
    end

    // capture the requested word one cycle after the strobe; a deselect drops any read in flight
    always_ff @(posedge sdr_clk_i) begin
        if (sdr_rst_i) begin
            rd_pend_q <= 1'b0;
            word_q    <= '0;
        end else begin
            rd_pend_q <= mem_re_q && !ss_s;
            if (rd_pend_q && !ss_s)
                word_q <= mem_data_i;
        end
    end
endmodule
